// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO bus arbiter.
//   state_t  : arbiter FSM states (IDLE, POP, DELIVER)
//   BCAST_ID : default broadcast destination ID
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DELIVER
  } state_t;

  localparam logic [7:0] BCAST_ID = 8'hFF;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection, purely combinational.
//   pndng      : request vector, one bit per FIFO
//   last_grant : index of the previous winner; search starts one above it
//   winner     : first requesting index at or after last_grant+1 (mod drvrs);
//                equals last_grant when nothing is pending
module rr_picker #(
  parameter int unsigned drvrs = 4,
  parameter int unsigned idx_w = $clog2(drvrs)
) (
  input  logic [drvrs-1:0] pndng,
  input  logic [idx_w-1:0] last_grant,
  output logic [idx_w-1:0] winner
);

  int idx;

  // Walk from the farthest candidate to the nearest so the nearest
  // requesting index is the last one written.
  always_comb begin
    winner = last_grant;
    idx    = 0;
    for (int k = int'(drvrs); k >= 1; k--) begin
      idx = (int'(last_grant) + k) % int'(drvrs);
      if (pndng[idx]) begin
        winner = idx_w'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_bus_arbiter.sv
// Moves packets from drvrs show-ahead source FIFOs onto a shared bus that
// feeds the same set of FIFOs. One packet at a time: pick a source
// round-robin, pop it, then push to the destination(s) named in the packet's
// top id_sz bits. Packets with an unknown destination are counted and dropped.
//   clk, reset : clock, synchronous active-high reset
//   pndng      : per-FIFO non-empty flags
//   D_pop      : per-FIFO head words
//   pop        : one-cycle dequeue strobe
//   full       : per-FIFO full flags (destination side)
//   push       : one-cycle enqueue strobe(s)
//   D_push     : data for all destinations
//   busy       : arbiter is not idle
//   drop_cnt   : saturating count of dropped packets
// Build option: define FIFO_BUS_ARBITER_BCAST_EN to deliver packets addressed
// to bcast to every FIFO except the source; otherwise they are dropped.
module fifo_bus_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned      pckg_sz = 16,
  parameter int unsigned      drvrs   = 4,
  parameter int unsigned      id_sz   = 8,
  parameter logic [id_sz-1:0] bcast   = id_sz'(BCAST_ID)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  input  logic [drvrs-1:0]                full,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output logic                            busy,
  output logic [7:0]                      drop_cnt
);

  localparam int unsigned      IdxW   = $clog2(drvrs);
  localparam logic [drvrs-1:0] OneHot = drvrs'(1);

  state_t             state_q, state_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]    last_grant_q;
  logic [IdxW-1:0]    winner;
  logic [pckg_sz-1:0] hold_q;
  logic [pckg_sz-1:0] last_push_q;
  logic [7:0]         drop_q;
  logic [id_sz-1:0]   dest;
  logic [drvrs-1:0]   targets;
  logic               fire;
  logic               drop;

  rr_picker #(
    .drvrs (drvrs),
    .idx_w (IdxW)
  ) u_rr_picker (
    .pndng      (pndng),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  assign dest = hold_q[pckg_sz-1 -: id_sz];

  // Empty target set marks the packet as undeliverable.
  always_comb begin
    targets = '0;
    if (32'(dest) < drvrs) begin
      targets = OneHot << dest;
    end
`ifdef FIFO_BUS_ARBITER_BCAST_EN
    if (dest == bcast) begin
      targets = ~(OneHot << grant_q);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pop     = '0;
    push    = '0;
    fire    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pndng) begin
          grant_d = winner;
          state_d = POP;
        end
      end
      POP: begin
        pop     = OneHot << grant_q;
        state_d = DELIVER;
      end
      DELIVER: begin
        if (targets == '0) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else if ((full & targets) == '0) begin
          // A reset arriving in the delivery cycle abandons the packet.
          fire    = ~reset;
          push    = reset ? '0 : targets;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IdxW'(drvrs - 1);
      hold_q       <= '0;
      last_push_q  <= '0;
      drop_q       <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (state_q == POP) begin
        hold_q       <= D_pop[grant_q];
        last_grant_q <= grant_q;
      end
      if (fire) begin
        last_push_q <= hold_q;
      end
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Bus shows the packet only in its push cycle, otherwise the previous one.
  assign D_push   = fire ? hold_q : last_push_q;
  assign busy     = (state_q != IDLE);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fifo_bus_arbiter.sv
// Self-checking bench for fifo_bus_arbiter (drvrs=4, pckg_sz=16, id_sz=8).
// Directed scenarios first, then a randomized run against a queue-based model
// of the source FIFOs and the delivery rules.
module tb_fifo_bus_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       pndng;
  logic [3:0][15:0] d_pop;
  logic [3:0]       pop;
  logic [3:0]       full;
  logic [3:0]       push;
  logic [15:0]      d_push;
  logic             busy;
  logic [7:0]       drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fifo_bus_arbiter #(
    .pckg_sz (16),
    .drvrs   (4),
    .id_sz   (8),
    .bcast   (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (d_pop),
    .pop      (pop),
    .full     (full),
    .push     (push),
    .D_push   (d_push),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] p, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (p[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] targets_of(input logic [15:0] pkt, input int src);
    logic [7:0] d;
    d = pkt[15:8];
    if (d < 8'd4) return 4'(1) << d;
`ifdef FIFO_BUS_ARBITER_BCAST_EN
    if (d == 8'hFF) return 4'hF & ~(4'(1) << src);
`endif
    return 4'h0;
  endfunction

  // Offer one packet from src alone; returns mid-way through the delivery cycle.
  task automatic send_one(input int src, input logic [15:0] data);
    step();
    pndng      = 4'(1) << src;
    d_pop[src] = data;
    step();
    pndng = 4'h0;
    @(negedge clk);
    check_eq("send_pop", 32'(pop), 32'(1) << src);
    step();
    @(negedge clk);
  endtask

  // Random-phase model state
  logic [15:0] q [4][$];
  int          phase;
  int          w;
  int          m_last;
  int          deq;
  logic [7:0]  m_drop;
  logic [15:0] last_d;
  logic [15:0] pkt;
  logic [3:0]  tgt;
  logic [7:0]  e_drop;

  initial begin
    reset = 1'b1;
    pndng = '0;
    full  = '0;
    d_pop = '0;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_pop", 32'(pop), 32'h0);
    check_eq("rst_push", 32'(push), 32'h0);
    check_eq("rst_dpush", 32'(d_push), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_drop", 32'(drop_cnt), 32'h0);
    step();
    reset = 1'b0;

    // Scenario 1: latency pop at +1, push at +2
    step();
    pndng    = 4'b0001;
    d_pop[0] = 16'h0255;
    @(negedge clk);
    check_eq("s1_idle_pop", 32'(pop), 32'h0);
    step();
    pndng = 4'b0000;
    @(negedge clk);
    check_eq("s1_pop", 32'(pop), 32'h1);
    check_eq("s1_pop_nopush", 32'(push), 32'h0);
    step();
    @(negedge clk);
    check_eq("s1_push", 32'(push), 32'h4);
    check_eq("s1_dpush", 32'(d_push), 32'h0255);
    check_eq("s1_push_nopop", 32'(pop), 32'h0);
    step();
    @(negedge clk);
    check_eq("s1_busy_after", 32'(busy), 32'h0);
    check_eq("s1_push_after", 32'(push), 32'h0);
    check_eq("s1_dpush_held", 32'(d_push), 32'h0255);

    // Scenario 3: destination full stalls delivery
    full = 4'b0100;
    send_one(0, 16'h02AB);
    for (int i = 0; i < 5; i++) begin
      check_eq("s3_stall_push", 32'(push), 32'h0);
      check_eq("s3_stall_busy", 32'(busy), 32'h1);
      check_eq("s3_stall_dpush", 32'(d_push), 32'h0255);
      if (i < 4) @(negedge clk);
    end
    step();
    full = 4'b0000;
    @(negedge clk);
    check_eq("s3_push", 32'(push), 32'h4);
    check_eq("s3_dpush", 32'(d_push), 32'h02AB);
    step();
    @(negedge clk);
    check_eq("s3_idle", 32'(busy), 32'h0);

    // Scenario 5: broadcast from source 1
    send_one(1, 16'hFF12);
`ifdef FIFO_BUS_ARBITER_BCAST_EN
    check_eq("s5_push", 32'(push), 32'hD);
    e_drop = 8'd0;
`else
    check_eq("s5_push", 32'(push), 32'h0);
    e_drop = 8'd1;
`endif
    step();
    @(negedge clk);
    check_eq("s5_drop", 32'(drop_cnt), 32'(e_drop));

    // Scenario 4: invalid destination, then saturation
    send_one(0, 16'h0711);
    check_eq("s4_nopush", 32'(push), 32'h0);
    step();
    @(negedge clk);
    check_eq("s4_drop_inc", 32'(drop_cnt), 32'(e_drop) + 32'd1);
    for (int i = 0; i < 299; i++) send_one(0, 16'h0711);
    step();
    @(negedge clk);
    check_eq("s4_drop_sat", 32'(drop_cnt), 32'hFF);

    // Scenario 6: reset in DELIVER, then scenario 2 round-robin order
    send_one(0, 16'h0255);
    reset = 1'b1;
    #1;
    check_eq("s6_nopush", 32'(push), 32'h0);
    step();
    @(negedge clk);
    check_eq("s6_pop", 32'(pop), 32'h0);
    check_eq("s6_push", 32'(push), 32'h0);
    check_eq("s6_busy", 32'(busy), 32'h0);
    check_eq("s6_drop", 32'(drop_cnt), 32'h0);
    check_eq("s6_dpush", 32'(d_push), 32'h0);
    step();
    reset = 1'b0;
    pndng = 4'b1111;
    for (int i = 0; i < 4; i++) d_pop[i] = {8'((i + 1) % 4), 8'(8'h30 + i)};
    for (int n = 0; n < 5; n++) begin
      step();
      @(negedge clk);
      check_eq("s2_pop", 32'(pop), 32'(1) << (n % 4));
      step();
      @(negedge clk);
      check_eq("s2_push", 32'(push), 32'(1) << ((n + 1) % 4));
      check_eq("s2_dpush", 32'(d_push), 32'({8'(((n % 4) + 1) % 4), 8'(8'h30 + (n % 4))}));
      step();
      @(negedge clk);
      check_eq("s2_gap", 32'({pop, push}), 32'h0);
    end

    // Randomized run against the queue model
    step();
    reset = 1'b1;
    pndng = '0;
    full  = '0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    phase  = 0;
    w      = 0;
    m_last = 3;
    deq    = -1;
    m_drop = 8'd0;
    last_d = 16'h0;
    pkt    = 16'h0;
    tgt    = 4'h0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      if (deq >= 0) begin
        void'(q[deq].pop_front());
        deq = -1;
      end
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() < 4 && $urandom_range(0, 3) == 0) begin
          int r;
          logic [7:0] d;
          r = $urandom_range(0, 9);
          d = (r < 7) ? 8'($urandom_range(0, 3)) : ((r < 9) ? 8'h07 : 8'hFF);
          q[i].push_back({d, 8'($urandom)});
        end
        pndng[i] = (q[i].size() != 0);
        d_pop[i] = (q[i].size() != 0) ? q[i][0] : 16'($urandom);
        full[i]  = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      check_eq("r_drop", 32'(drop_cnt), 32'(m_drop));
      case (phase)
        0: begin
          check_eq("r_idle_pop", 32'(pop), 32'h0);
          check_eq("r_idle_push", 32'(push), 32'h0);
          check_eq("r_idle_busy", 32'(busy), 32'h0);
          check_eq("r_idle_dpush", 32'(d_push), 32'(last_d));
          if (pndng != 4'h0) begin
            w     = rr_pick(pndng, m_last);
            phase = 1;
          end
        end
        1: begin
          check_eq("r_pop", 32'(pop), 32'(1) << w);
          check_eq("r_pop_push", 32'(push), 32'h0);
          check_eq("r_pop_busy", 32'(busy), 32'h1);
          pkt    = q[w][0];
          deq    = w;
          m_last = w;
          tgt    = targets_of(pkt, w);
          phase  = 2;
        end
        default: begin
          check_eq("r_dlv_pop", 32'(pop), 32'h0);
          check_eq("r_dlv_busy", 32'(busy), 32'h1);
          if (tgt == 4'h0) begin
            check_eq("r_drop_push", 32'(push), 32'h0);
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            phase = 0;
          end else if ((full & tgt) == 4'h0) begin
            check_eq("r_push", 32'(push), 32'(tgt));
            check_eq("r_dpush", 32'(d_push), 32'(pkt));
            last_d = pkt;
            phase  = 0;
          end else begin
            check_eq("r_stall_push", 32'(push), 32'h0);
            check_eq("r_stall_dpush", 32'(d_push), 32'(last_d));
          end
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_bus_arbiter.md
FIFO_BUS_ARBITER -- requirements
Module: fifo_bus_arbiter

Interface
REQ-001 The block SHALL have parameter pckg_sz, default 16: packet width in bits.
REQ-002 The block SHALL have parameter drvrs, default 4: number of attached device FIFOs, range 2..16.
REQ-003 The block SHALL have parameter id_sz, default 8: width of the destination-ID field, which occupies packet bits [pckg_sz-1 : pckg_sz-id_sz].
REQ-004 The block SHALL have parameter bcast, default 8'hFF: the broadcast destination ID.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port pndng, input, [drvrs-1:0]: FIFO i is non-empty.
REQ-008 Port D_pop, input, [drvrs-1:0][pckg_sz-1:0]: show-ahead head word of each FIFO.
REQ-009 Port pop, output, [drvrs-1:0]: one-cycle dequeue strobe to FIFO i.
REQ-010 Port full, input, [drvrs-1:0]: destination FIFO j cannot accept a word.
REQ-011 Port push, output, [drvrs-1:0]: one-cycle enqueue strobe to FIFO j.
REQ-012 Port D_push, output, [pckg_sz-1:0]: data shared by all destinations.
REQ-013 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 Port drop_cnt, output, 8 bits: count of dropped packets, saturating at 8'hFF.

Function
REQ-015 The FSM SHALL have states IDLE, POP and DELIVER.
REQ-016 IDLE: if pndng != 0, the block SHALL pick a winner round-robin, starting the search at last_grant+1 modulo drvrs, register it as grant and go to POP; otherwise it SHALL stay in IDLE.
REQ-017 POP: the block SHALL assert pop[grant] for exactly one cycle, latch D_pop[grant] into hold, set last_grant = grant and go to DELIVER.
REQ-018 DELIVER, unicast: dest = hold[MSB -: id_sz]; if dest < drvrs, the target set is {dest}.
REQ-019 DELIVER, invalid destination: any other dest (including bcast when broadcast is compiled out) SHALL be dropped: drop_cnt += 1, saturating, with no push, then return to IDLE.
REQ-020 DELIVER SHALL hold while (full & targets) != 0; once that term is clear it SHALL assert push = targets for one cycle, drive D_push = hold in the same cycle, then return to IDLE.
REQ-021 Latency: the first pndng sample leads to pop one cycle later and push two cycles later when no destination is full; minimum period is 3 cycles per packet.
REQ-022 Unicast to the source's own FIFO is legal and SHALL be delivered.
REQ-023 pop and push SHALL never be high in the same cycle; at most one pop bit SHALL be set at a time.
REQ-024 When outside DELIVER's push cycle, D_push SHALL hold its last value; in that cycle, push SHALL be 0.
REQ-025 Changes on pndng during POP or DELIVER SHALL be ignored until the block returns to IDLE.

Reset
REQ-026 While reset is high at a clock edge, the block SHALL clear state to IDLE, pop=0, push=0, D_push=0, hold=0, busy=0 and drop_cnt=0, and set last_grant=drvrs-1 so that FIFO 0 wins first.
REQ-027 A reset asserted in POP or DELIVER SHALL abandon the in-flight packet with no push; a word already popped is lost.

Configuration
REQ-028 The feature macro SHALL be FIFO_BUS_ARBITER_BCAST_EN.
REQ-029 With FIFO_BUS_ARBITER_BCAST_EN defined, dest == bcast SHALL make targets all ones except bit grant, and delivery SHALL wait until none of those targets is full.
REQ-030 With FIFO_BUS_ARBITER_BCAST_EN undefined, dest == bcast SHALL be treated as an invalid destination and dropped per REQ-019.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum (IDLE, POP, DELIVER) and the default BCAST_ID constant 8'hFF.
REQ-032 Sub-module rr_picker SHALL compute the winner index combinationally from pndng and last_grant, and SHALL be instantiated once.

Verification
REQ-033 Scenario 1: after reset, pndng=4'b0001, D_pop[0]=16'h0255, full=0 -> pop=4'b0001 at cycle+1, then push=4'b0100 with D_push=16'h0255 at cycle+2.
REQ-034 Scenario 2: pndng=4'b1111 held with valid dests -> grants in order 0,1,2,3,0, one packet every 3 cycles.
REQ-035 Scenario 3: dest=2 with full[2]=1 for 5 cycles -> busy stays high and push stays 0; push=4'b0100 in the first cycle after full[2] drops.
REQ-036 Scenario 4: dest=8'h07 with drvrs=4 -> no push, drop_cnt goes 0->1; after 300 such packets drop_cnt == 8'hFF.
REQ-037 Scenario 5: source 1, dest=8'hFF -> with the macro, push=4'b1101; without the macro, the packet is dropped and drop_cnt increments.
REQ-038 Scenario 6: reset pulsed during DELIVER -> no push; on the next cycle all outputs are 0 and the next grant goes to FIFO 0.
